// File: rtl/network_div_seq_27s_11ns_16.sv
// Sequential radix-2 restoring divider: signed 27-bit dividend / unsigned 11-bit divisor -> saturated 16-bit quotient + remainder.
// Optional round-half-away-from-zero on the quotient when NETWORK_DIV_ROUND_EN is defined.
module network_div_seq_27s_11ns_16 #(
  parameter int DIVIDEND_W = 27,
  parameter int DIVISOR_W  = 11,
  parameter int QUOT_W     = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] din0,
  input  logic [DIVISOR_W-1:0]  din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QUOT_W-1:0]     quot,
  output logic [DIVISOR_W:0]    rem,
  output logic                  ovf,
  output logic                  dz,
  output logic [1:0]            o_dbg_state
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [QUOT_W-1:0]     QMAX    = {1'b0, {(QUOT_W-1){1'b1}}};
  localparam logic [QUOT_W-1:0]     QMIN    = {1'b1, {(QUOT_W-1){1'b0}}};
  localparam logic [DIVIDEND_W-1:0] POS_LIM = DIVIDEND_W'(QMAX);
  localparam logic [DIVIDEND_W-1:0] NEG_LIM = DIVIDEND_W'(QMIN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t                r_state, w_next;
  logic                  r_neg, r_dz;
  logic [DIVIDEND_W-1:0] r_mag, r_quo;
  logic [DIVISOR_W-1:0]  r_div;
  logic [DIVISOR_W:0]    r_prem;
  logic [CNT_W-1:0]      r_cnt;

  logic [DIVISOR_W:0]    w_trial, w_sub;
  logic                  w_ge;
  logic [DIVIDEND_W-1:0] w_mag_in, w_qmag;
  logic [QUOT_W-1:0]     w_quot_fix;
  logic [DIVISOR_W:0]    w_rem_fix;
  logic                  w_ovf_fix;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and DONE holds until out_ready.
  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign o_dbg_state = r_state;

  assign w_mag_in = din0[DIVIDEND_W-1] ? (~din0 + 1'b1) : din0;
  assign w_trial  = {r_prem[DIVISOR_W-1:0], r_mag[DIVIDEND_W-1]};
  assign w_ge     = (w_trial >= {1'b0, r_div});
  assign w_sub    = w_trial - {1'b0, r_div};

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_next = (din1 == '0) ? S_FIX : S_CALC;
      S_CALC: if (r_cnt == '0) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

`ifdef NETWORK_DIV_ROUND_EN
  logic w_round;
  // The partial remainder is already below the divisor, so doubling it fits in DIVISOR_W+1 bits.
  assign w_round = ({r_prem[DIVISOR_W-1:0], 1'b0} >= {1'b0, r_div});
  assign w_qmag  = r_quo + {{(DIVIDEND_W-1){1'b0}}, w_round};
`else
  assign w_qmag  = r_quo;
`endif

  always_comb begin
    w_quot_fix = '0;
    w_rem_fix  = '0;
    w_ovf_fix  = 1'b0;
    if (r_dz) begin
      w_quot_fix = r_neg ? QMIN : QMAX;
    end else if (!r_neg) begin
      w_rem_fix = r_prem;
      if (w_qmag > POS_LIM) begin
        w_quot_fix = QMAX;
        w_ovf_fix  = 1'b1;
      end else begin
        w_quot_fix = w_qmag[QUOT_W-1:0];
      end
    end else begin
      w_rem_fix = ~r_prem + 1'b1;
      if (w_qmag > NEG_LIM) begin
        w_quot_fix = QMIN;
        w_ovf_fix  = 1'b1;
      end else begin
        w_quot_fix = ~w_qmag[QUOT_W-1:0] + 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_neg  <= 1'b0;
      r_dz   <= 1'b0;
      r_mag  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_prem <= '0;
      r_cnt  <= '0;
      quot   <= '0;
      rem    <= '0;
      ovf    <= 1'b0;
      dz     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_neg  <= din0[DIVIDEND_W-1];
          r_dz   <= (din1 == '0);
          r_mag  <= w_mag_in;
          r_div  <= din1;
          r_quo  <= '0;
          r_prem <= '0;
          r_cnt  <= CNT_W'(DIVIDEND_W - 1);
        end
        S_CALC: begin
          r_prem <= w_ge ? w_sub : w_trial;
          r_quo  <= {r_quo[DIVIDEND_W-2:0], w_ge};
          r_mag  <= {r_mag[DIVIDEND_W-2:0], 1'b0};
          r_cnt  <= r_cnt - 1'b1;
        end
        S_FIX: begin
          quot <= w_quot_fix;
          rem  <= w_rem_fix;
          ovf  <= w_ovf_fix;
          dz   <= r_dz;
        end
        S_DONE: if (out_ready) begin
          ovf <= 1'b0;
          dz  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_network_div_seq_27s_11ns_16.sv
// Scoreboard bench for network_div_seq_27s_11ns_16: driver pushes model results, a monitor checks each result as it appears.
module tb_network_div_seq_27s_11ns_16;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [26:0] din0;
  logic [10:0] din1;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quot;
  logic [11:0] rem;
  logic        ovf;
  logic        dz;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc = 0;

  // expected entry packs {quot[15:0], rem[11:0], ovf, dz}
  logic [29:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];

  network_div_seq_27s_11ns_16 dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .din0       (din0),
    .din1       (din1),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quot       (quot),
    .rem        (rem),
    .ovf        (ovf),
    .dz         (dz),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 ap_clk = ~ap_clk;
  initial forever begin
    @(posedge ap_clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: plain signed integer division, truncation toward zero, then optional rounding and saturation.
  function automatic logic [29:0] model(input logic signed [26:0] a, input logic [10:0] b);
    longint sa, sb, q, r, ar;
    logic   ov, z;
    logic [15:0] qo;
    logic [11:0] ro;
    sa = longint'(a);
    sb = longint'(b);
    ov = 1'b0;
    z  = 1'b0;
    if (sb == 0) begin
      z = 1'b1;
      r = 0;
      q = (sa >= 0) ? 32767 : -32768;
    end else begin
      q = sa / sb;
      r = sa % sb;
`ifdef NETWORK_DIV_ROUND_EN
      ar = (r < 0) ? -r : r;
      if (2 * ar >= sb) q = q + ((sa < 0) ? -1 : 1);
`else
      ar = 0;
`endif
      if (q > 32767) begin
        q = 32767;
        ov = 1'b1;
      end else if (q < -32768) begin
        q = -32768;
        ov = 1'b1;
      end
    end
    qo = q[15:0];
    ro = r[11:0];
    return {qo, ro, ov, z};
  endfunction

  // driver
  task automatic issue(input logic [26:0] a, input logic [10:0] b);
    int n = 0;
    @(negedge ap_clk);
    while (!in_ready && n < 300) begin
      @(negedge ap_clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    din0     = a;
    din1     = b;
    in_valid = 1'b1;
    exp_q.push_back(model(a, b));
    lat_q.push_back((b == 0) ? 1 : 28);
    @(posedge ap_clk);
    #1;
    acc_q.push_back(cyc);
    last_acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 400) begin
      @(negedge ap_clk);
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // monitor: checks every result on the cycle out_valid rises
  initial begin
    logic prev = 1'b0;
    logic [29:0] e;
    int lat, acc;
    forever begin
      @(negedge ap_clk);
      if (ap_rst_n && out_valid && !prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          e   = exp_q.pop_front();
          lat = lat_q.pop_front();
          acc = acc_q.pop_front();
          chk("quot",    32'(quot), 32'(e[29:14]));
          chk("rem",     32'(rem),  32'(e[13:2]));
          chk("ovf",     32'(ovf),  32'(e[1]));
          chk("dz",      32'(dz),   32'(e[0]));
          chk("latency", 32'(cyc - acc), 32'(lat));
        end
      end
      prev = out_valid;
    end
  end

  initial begin
    logic [29:0] e;
    logic        hold_ok;
    int          t0, n;
    logic [26:0] ra;
    logic [10:0] rb;

    ap_rst_n  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    din0      = '0;
    din1      = '0;
    #12;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quot",      32'(quot),      32'd0);
    chk("rst_rem",       32'(rem),       32'd0);
    chk("rst_ovf",       32'(ovf),       32'd0);
    chk("rst_dz",        32'(dz),        32'd0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // directed cases, with back-to-back issue interval
    issue(27'd1000, 11'd7);
    t0 = last_acc;
    issue(-27'sd1000, 11'd7);
    chk("issue_interval", 32'(last_acc - t0), 32'd30);
    issue(27'd999, 11'd2);
    issue(27'd67108863, 11'd1);
    issue(27'h4000000, 11'd1);
    issue(-27'sd32768, 11'd1);
    issue(27'd5, 11'd0);
    issue(-27'sd5, 11'd0);
    issue(27'd0, 11'd5);
    issue(-27'sd3, 11'd7);
    issue(27'd65535, 11'd2);
    issue(27'd2047, 11'd2047);

    // randomized operands; magnitude range varied so both saturating and in-range results occur
    for (int i = 0; i < 40; i++) begin
      ra = 27'($urandom);
      if ($urandom_range(0, 1) == 1) ra = 27'($signed(ra) >>> $urandom_range(4, 20));
      rb = ($urandom_range(0, 9) == 0) ? 11'd0 : 11'($urandom_range(1, 2047));
      issue(ra, rb);
    end
    drain();

    // backpressure: result must hold with in_ready low; input pulses ignored
    out_ready = 1'b0;
    issue(27'd123456, 11'd77);
    e = model(27'd123456, 11'd77);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    hold_ok = out_valid;
    for (int i = 0; i < 50; i++) begin
      @(negedge ap_clk);
      in_valid = 1'($urandom_range(0, 1));
      din0     = 27'($urandom);
      din1     = 11'($urandom);
      #1;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || {quot, rem, ovf, dz} !== e) hold_ok = 1'b0;
    end
    in_valid = 1'b0;
    chk("backpressure_hold", 32'(hold_ok), 32'd1);
    @(negedge ap_clk);
    out_ready = 1'b1;
    issue(-27'sd4321, 11'd10);
    drain();

    // asynchronous reset in the middle of CALC discards the operation
    issue(27'd5000, 11'd13);
    repeat (10) @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b0;
    exp_q.delete();
    lat_q.delete();
    acc_q.delete();
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_quot",      32'(quot),      32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("postrst_in_ready",  32'(in_ready),  32'd1);
    chk("postrst_out_valid", 32'(out_valid), 32'd0);
    issue(27'd100, 11'd3);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/network_div_seq_27s_11ns_16.md
Name: network_div_seq_27s_11ns_16

Overview:
- Sequential fixed-point divider; the inverse of the network's 16s x 11ns -> 27-bit scale multiply.
- Takes a 27-bit signed accumulator/product and an 11-bit unsigned scale, and returns a saturated 16-bit signed quotient plus remainder.
- Used for requantizing and normalising layer outputs back to 16-bit activations.
- Radix-2 restoring division on magnitudes, one quotient bit per cycle, valid/ready on both sides.

Parameters:
- DIVIDEND_W, 27, dividend width (signed)
- DIVISOR_W, 11, divisor width (unsigned)
- QUOT_W, 16, output quotient width (signed, saturated)

Ports:
- ap_clk  in  1  clock, rising edge
- ap_rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- din0  in  27  dividend, signed
- din1  in  11  divisor, unsigned
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- quot  out  16  quotient, signed, saturated
- rem  out  12  remainder, signed, sign follows dividend
- ovf  out  1  quotient saturated (result did not fit QUOT_W)
- dz  out  1  divide by zero

Behaviour:
- Reset: state IDLE; in_ready=1; out_valid=0; quot=0; rem=0; ovf=0; dz=0; internal registers cleared.
- Reset mid-operation: the operation is discarded. No result is ever presented.
- States:
  - IDLE: in_ready=1. On in_valid at edge T, capture sign(din0), |din0| (27-bit unsigned; -2^26 maps to 2^26) and din1.
    - din1==0 -> FIX.
    - Otherwise -> CALC with bit counter=26 and partial remainder=0.
  - CALC: each edge, shift the next dividend magnitude bit (MSB first) into the partial remainder. If partial remainder >= divisor, subtract the divisor and set the quotient bit, else clear it. Counter decrements. After the counter-0 iteration -> FIX. Exactly 27 CALC cycles.
  - FIX: apply the dividend sign to the quotient magnitude and remainder, saturate, register the outputs. -> DONE.
  - DONE: out_valid=1, outputs stable. On out_ready -> IDLE; out_valid drops the next cycle.
- Handshakes:
  - in_ready=1 only in IDLE, so no input is accepted while busy or while holding a result.
  - Results are never lost under backpressure; DONE holds indefinitely.
- Latency, measured from the accept edge T:
  - Normal: out_valid rises after edge T+28.
  - Divide by zero: out_valid rises after edge T+1.
  - Minimum issue interval: 30 cycles with out_ready tied high.
- Arithmetic:
  - Quotient truncates toward zero. Remainder = dividend - quot_unsat*divisor, magnitude < divisor, zero when exact.
  - Saturation: positive magnitude > 32767 -> quot=32767, ovf=1. Negative magnitude > 32768 -> quot=-32768, ovf=1.
  - When ovf=1, rem still reports the true remainder.
  - Zero dividend -> quot=0, rem=0 (no -0 issue).
- Divide by zero:
  - dz=1, ovf=0, rem=0.
  - quot=32767 if dividend >= 0, else -32768.
- ovf/dz are valid only while out_valid=1 and clear on the DONE->IDLE transition.

Optional Feature:
- Macro: NETWORK_DIV_ROUND_EN.
- Defined: in FIX, if 2*|rem| >= divisor, increment the quotient magnitude before sign and saturation (round half away from zero). rem still reports the truncated remainder; latency is unchanged.
  - An increment that pushes the magnitude past the limit sets ovf and saturates.
- Undefined: truncation toward zero only; no incrementer is synthesised.

Test Plan:
- din0=1000, din1=7 -> quot=142, rem=6, ovf=0, dz=0; out_valid 28 cycles after accept. With ROUND_EN: quot=143.
- din0=-1000, din1=7 -> quot=-142, rem=-6. With ROUND_EN: quot=-143. Also din0=999, din1=2 with ROUND_EN -> quot=500.
- Saturation:
  - din0=67108863, din1=1 -> quot=32767, ovf=1.
  - din0=-67108864, din1=1 -> quot=-32768, ovf=1.
  - din0=-32768, din1=1 -> quot=-32768, ovf=0.
- Divide by zero: din0=5, din1=0 -> quot=32767, dz=1, out_valid after 1 cycle. din0=-5, din1=0 -> quot=-32768, dz=1.
- Backpressure: out_ready low for 50 cycles after a result -> out_valid and outputs stable, in_ready=0 throughout, and in_valid pulses are ignored. On out_ready=1 -> IDLE, next operand accepted.
- Async reset: drop ap_rst_n at CALC cycle 10 -> all outputs reset immediately, in_ready=1 after release, no stale out_valid. Next operation, din0=100, din1=3 -> quot=33, rem=1.
